clkdiv_ratio_ctrl: RTL

Control stage directly upstream of the odd 50%-duty clock divider. It owns that divider's `divbyvalue` and reset inputs, and accepts ratio-change requests over a valid/ready handshake. Each request is validated (odd, ≥3). Legal changes are applied only at a safe point: after a falling edge of the divided clock, with the divider held in reset for a fixed window. This keeps ratio changes free of runt or glitch pulses. A `locked` flag reports when the divider is running at the committed ratio.

---
 rtl/clkdiv_ratio_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/clkdiv_ratio_ctrl.sv
// clkdiv_ratio_ctrl
// Owns the divbyvalue and active-low reset inputs of an odd 50%-duty clock
// divider. Ratio-change requests arrive over a valid/ready handshake, are
// checked for legality (odd, >= 3) and are applied only at a safe point:
// just after a falling edge of the divided clock, with the divider held in
// reset for HOLD_CYCLES clkin cycles. 'locked' reports that the divider is
// running at the committed ratio.
module clkdiv_ratio_ctrl #(
    parameter int WIDTH       = 4,
    parameter int DEFAULT_DIV = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_div,
    output logic             req_ready,
    output logic             req_err,
    input  logic             clkout_fb,
    output logic [WIDTH-1:0] divbyvalue,
    output logic             div_rstn,
    output logic             busy,
    output logic             locked
);

    typedef enum logic [1:0] {
        INIT_HOLD = 2'd0,
        RUN       = 2'd1,
        WAIT_FALL = 2'd2,
        HOLD      = 2'd3
    } state_t;

    // Timeout counter is one bit wider than the ratio bus so it always
    // outlasts one full period of the slowest legal divided clock.
    localparam int              TO_W      = WIDTH + 1;
    localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0] TO_MAX    = '1;
    // The counter increments on the edge that leaves WAIT_FALL, so the
    // timeout fires on the edge where it would reach TO_MAX.
    localparam logic [TO_W-1:0] TO_LAST   = TO_MAX - TO_ONE;

    localparam logic [3:0]       HOLD_ONE  = 4'd1;
    localparam logic [3:0]       HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] DEF_DIV   = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DIV_ONE   = WIDTH'(1);

    state_t           state;
    state_t           next_state;
    logic [3:0]       hold_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [WIDTH-1:0] pend_div;
    logic             fb_d0;
    logic             fb_d1;

    logic fall_det;
    logic rise_det;
    logic accept;
    logic req_legal;
    logic req_change;
    logic timeout;

    // Edge detection on the twice-registered divider feedback.
    assign fall_det = fb_d1 & ~fb_d0;
    assign rise_det = ~fb_d1 & fb_d0;

    // Handshake qualification: legal ratios are odd and at least 3.
    assign accept     = req_valid & req_ready;
    assign req_legal  = req_div[0] & (req_div != DIV_ONE);
    assign req_change = accept & req_legal & (req_div != divbyvalue);
    assign timeout    = (to_cnt == TO_LAST);

    // Next-state decode.
    // NOTE: next_state is given its default before the case so every path
    // assigns it and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            INIT_HOLD: if (hold_cnt == HOLD_LAST) next_state = RUN;
            RUN:       if (req_change)            next_state = WAIT_FALL;
            WAIT_FALL: if (fall_det || timeout)   next_state = HOLD;
            HOLD:      if (hold_cnt == HOLD_LAST) next_state = RUN;
            default:                              next_state = INIT_HOLD;
        endcase
    end

    // State register, counters and feedback synchroniser.
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clkin) begin
        if (rst) begin
            state    <= INIT_HOLD;
            hold_cnt <= '0;
            to_cnt   <= '0;
            pend_div <= DEF_DIV;
            fb_d0    <= 1'b0;
            fb_d1    <= 1'b0;
        end else begin
            state <= next_state;
            fb_d0 <= clkout_fb;
            fb_d1 <= fb_d0;

            if (state != next_state) begin
                hold_cnt <= '0;
            end else if (state == INIT_HOLD || state == HOLD) begin
                hold_cnt <= hold_cnt + HOLD_ONE;
            end

            if (state == WAIT_FALL) begin
                to_cnt <= to_cnt + TO_ONE;
            end else begin
                to_cnt <= '0;
            end

            if (req_change) begin
                pend_div <= req_div;
            end
        end
    end

    // Registered outputs, decoded from the next state so they switch on the
    // same edge as the state itself and never glitch.
    always_ff @(posedge clkin) begin
        if (rst) begin
            div_rstn  <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            req_err   <= 1'b0;
        end else begin
            div_rstn  <= (next_state == RUN) || (next_state == WAIT_FALL);
            req_ready <= (next_state == RUN);
            busy      <= (next_state != RUN);
            req_err   <= accept & ~req_legal;
        end
    end

    // Ratio register: only loaded on entry to HOLD, when the divider goes
    // into reset on the same edge, so it never changes while it is running.
    always_ff @(posedge clkin) begin
        if (rst) begin
            divbyvalue <= DEF_DIV;
        end else if (state == WAIT_FALL && next_state == HOLD) begin
            divbyvalue <= pend_div;
        end
    end

    // Lock flag: cleared whenever the divider is (or is about to be) stopped,
    // set by the first divided-clock rising edge seen while running.
    always_ff @(posedge clkin) begin
        if (rst) begin
            locked <= 1'b0;
        end else if (state != RUN || next_state != RUN) begin
            locked <= 1'b0;
        end else if (rise_det) begin
            locked <= 1'b1;
        end
    end

endmodule
